// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Also holds the preload helper for the first mid-bit strobe.
package uart_rx_pkg;

  localparam int NUM_FRAME_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECEIVE,
    STOP_CHK,
    LOAD
  } rx_state_t;

  // The counter is loaded in START and counts down from T0+2 onward.
  // Reaching zero after this many cycles puts strobe 0 at T0 + 1.5 bit periods.
  function automatic int first_strobe_preload(input int clks_per_bit);
    return (3 * clks_per_bit) / 2 - 2;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Clock and bit counters for the receive controller.
// Produces mid-bit shift strobes and flags the strobe that completes the frame.
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic shift_strobe,
  output logic frame_done
);

  localparam int CW = $clog2(2 * CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_FRAME_BITS + 1);
  localparam logic [CW-1:0] PRELOAD = CW'(first_strobe_preload(CLKS_PER_BIT));
  localparam logic [CW-1:0] RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_FRAME_BITS - 1);

  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;

  assign shift_strobe = enable && (clk_cnt == '0);
  assign frame_done   = shift_strobe && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      clk_cnt <= PRELOAD;
      bit_cnt <= '0;
    end else if (enable) begin
      if (clk_cnt == '0) begin
        clk_cnt <= RELOAD;
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        clk_cnt <= clk_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control FSM: sequences the 9-bit shift register, checks the
// stop bit, then either loads the receive buffer or raises a sticky framing error.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic sbc_clear,
  output logic sbc_enable,
  output logic load_buffer,
  output logic framing_error,
  output logic busy
);

  rx_state_t state, next_state;
  logic      frame_done;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (state == START),
    .enable      (state == RECEIVE),
    .shift_strobe(shift_strobe),
    .frame_done  (frame_done)
  );

  // The error flag clears on the edge entering START so it is already low there.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= IDLE;
      framing_error <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start_bit_detected) begin
        framing_error <= 1'b0;
      end else if (state == STOP_CHK && !stop_bit) begin
        framing_error <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_bit_detected) next_state = START;
      START:    next_state = RECEIVE;
      RECEIVE:  if (frame_done) next_state = STOP_CHK;
      STOP_CHK: next_state = stop_bit ? LOAD : IDLE;
      LOAD:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  assign sbc_clear   = (state == START);
  assign sbc_enable  = (state == STOP_CHK);
  assign load_buffer = (state == LOAD);
  assign busy        = (state != IDLE);

endmodule
